// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART state encoding and default frame/timing constants.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 10416;
    localparam int DATA_BITS_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock FIFO, head entry presented from the register array.
// Revision : 1.0
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (count_q == FULL_LVL);
    assign o_empty   = (count_q == '0);
    assign o_level   = count_q;
    assign o_data    = mem_q[rd_ptr_q];
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deser
// Brief    : UART receiver (8N1, LSB first) with output FIFO and ready/valid.
//            Define UART_RX_PARITY_EN to add an even-parity bit and o_parity_err.
// Revision : 1.0
// ============================================================================
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_rx,
    output logic [DATA_BITS-1:0]        o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                        o_parity_err,
`endif
    output logic                        o_overflow
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int                 IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, overflow_q;
    logic                 w_rx_s, w_mid, w_push, w_frame_err, w_pop, w_full, w_empty;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d, parity_err_q, w_parity_err;
`endif

    assign w_rx_s = sync2_q;
    assign w_mid  = (cnt_q == CNT_LAST);
    assign w_pop  = ~w_empty & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= i_rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= w_frame_err;
            overflow_q  <= w_push & w_full & ~w_pop;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= w_parity_err;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == IDLE || w_mid) ? '0 : cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        w_parity_err = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (!w_rx_s) state_d = START;
            end
            // Restarting the counter at the half-bit point moves every later
            // sample to mid-bit.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_mid) begin
                    shift_d = {w_rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_mid) begin
                    par_bad_d = w_rx_s ^ (^shift_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (w_mid) begin
                    state_d = IDLE;
                    if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_push = ~par_bad_q;
`else
                        w_push = 1'b1;
`endif
                    end else begin
                        w_frame_err = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    w_parity_err = par_bad_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (shift_q),
        .i_pop   (w_pop),
        .o_data  (o_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    assign o_valid     = ~w_empty;
    assign o_busy      = (state_q != IDLE);
    assign o_frame_err = frame_err_q;
    assign o_overflow  = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deser
// Brief    : Directed, table-driven self-checking bench for uart_rx_deser.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_deser;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, busy, ferr, ovf;
    logic [2:0] level;
`ifdef UART_RX_PARITY_EN
    logic       perr;
    logic       par_force = 1'b0;
    logic       par_val = 1'b0;
    int         n_perr = 0;
`endif

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         valid_cyc = 0;
    int         n_valid = 0, n_ferr = 0, n_ovf = 0, n_busy = 0;
    logic [7:0] rx_bytes [64];

    uart_rx_deser #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx         (rx),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_busy       (busy),
        .o_level      (level),
        .o_frame_err  (ferr),
`ifdef UART_RX_PARITY_EN
        .o_parity_err (perr),
`endif
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && ready) begin
            if (n_valid < 64) rx_bytes[n_valid] <= data;
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (ferr) n_ferr <= n_ferr + 1;
        if (ovf)  n_ovf  <= n_ovf + 1;
        if (busy) n_busy <= n_busy + 1;
`ifdef UART_RX_PARITY_EN
        if (perr) n_perr <= n_perr + 1;
`endif
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        @(posedge clk); #1;
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (CPB) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx = par_force ? par_val : ^d;
        repeat (CPB) @(posedge clk);
`endif
        #1 rx = stop_b;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    vec_t vecs [6];
    int   s_valid, s_ferr, s_ovf, s_busy;

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1, exp_data: 8'hA5, exp_ferr: 0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_valid: 0, exp_data: 8'h00, exp_ferr: 1};
        vecs[2] = '{data: 8'h5A, stop: 1'b1, exp_valid: 1, exp_data: 8'h5A, exp_ferr: 0};
        vecs[3] = '{data: 8'h00, stop: 1'b1, exp_valid: 1, exp_data: 8'h00, exp_ferr: 0};
        vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_data: 8'hFF, exp_ferr: 0};
        vecs[5] = '{data: 8'h81, stop: 1'b0, exp_valid: 0, exp_data: 8'h00, exp_ferr: 1};

        repeat (3) @(negedge clk);
        check("rst_valid", int'(valid), 0);
        check("rst_data",  int'(data),  0);
        check("rst_busy",  int'(busy),  0);
        check("rst_level", int'(level), 0);
        check("rst_ferr",  int'(ferr),  0);
        check("rst_ovf",   int'(ovf),   0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int v = 0; v < 6; v++) begin
            s_valid = n_valid; s_ferr = n_ferr; s_ovf = n_ovf;
            send_frame(vecs[v].data, vecs[v].stop);
            repeat (20) @(posedge clk);
            check($sformatf("vec%0d_nvalid", v), n_valid - s_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d_nferr", v),  n_ferr - s_ferr,   vecs[v].exp_ferr);
            check($sformatf("vec%0d_novf", v),   n_ovf - s_ovf,     0);
            if (vecs[v].exp_valid == 1) begin
                check($sformatf("vec%0d_data", v),    int'(rx_bytes[s_valid]), int'(vecs[v].exp_data));
                check($sformatf("vec%0d_latency", v), valid_cyc - start_cyc,  LAT);
            end
        end

        // Short low glitch shorter than half a bit.
        s_valid = n_valid; s_ferr = n_ferr; s_busy = n_busy;
        @(posedge clk); #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_cycles", n_busy - s_busy, 8);
        check("glitch_busy_end",    int'(busy), 0);
        check("glitch_nvalid",      n_valid - s_valid, 0);
        check("glitch_nferr",       n_ferr - s_ferr, 0);

        // Fill the FIFO with the consumer stalled, then overflow it.
        @(posedge clk); #1 ready = 1'b0;
        s_valid = n_valid; s_ovf = n_ovf;
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
        @(negedge clk);
        check("fill_level",   int'(level), 4);
        check("fill_novf",    n_ovf - s_ovf, 0);
        check("fill_valid",   int'(valid), 1);
        send_frame(8'h05, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ovf_count",    n_ovf - s_ovf, 1);
        check("ovf_level",    int'(level), 4);
        @(posedge clk); #1 ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_nvalid", n_valid - s_valid, 4);
        for (int b = 0; b < 4; b++)
            check($sformatf("drain_byte%0d", b), int'(rx_bytes[s_valid + b]), b + 1);
        check("drain_level",  int'(level), 0);
        check("drain_valid",  int'(valid), 0);

        // Reset mid-frame with a byte waiting in the FIFO.
        @(posedge clk); #1 ready = 1'b0;
        send_frame(8'h11, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("prerst_level", int'(level), 1);
        @(posedge clk); #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 rx = (i == 1);
            repeat (CPB) @(posedge clk);
        end
        #1 rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        @(negedge clk);
        check("prerst_busy", int'(busy), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy",  int'(busy),  0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_level", int'(level), 0);
        check("midrst_data",  int'(data),  0);
        check("midrst_ferr",  int'(ferr),  0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; ready = 1'b1;
        repeat (5) @(posedge clk);
        s_valid = n_valid; s_ferr = n_ferr;
        send_frame(8'h7E, 1'b1);
        repeat (20) @(posedge clk);
        check("postrst_nvalid", n_valid - s_valid, 1);
        check("postrst_data",   int'(rx_bytes[s_valid]), 8'h7E);
        check("postrst_nferr",  n_ferr - s_ferr, 0);

`ifdef UART_RX_PARITY_EN
        begin
            int s_perr;
            s_valid = n_valid; s_perr = n_perr; s_ferr = n_ferr;
            par_force = 1'b1; par_val = 1'b0;
            send_frame(8'h07, 1'b1);
            repeat (20) @(posedge clk);
            check("parbad_nperr",  n_perr - s_perr, 1);
            check("parbad_nvalid", n_valid - s_valid, 0);
            check("parbad_nferr",  n_ferr - s_ferr, 0);
            s_valid = n_valid; s_perr = n_perr;
            par_val = 1'b1;
            send_frame(8'h07, 1'b1);
            repeat (20) @(posedge clk);
            check("pargood_nperr",  n_perr - s_perr, 0);
            check("pargood_nvalid", n_valid - s_valid, 1);
            check("pargood_data",   int'(rx_bytes[s_valid]), 8'h07);
            par_force = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
